// File: rtl/result_uart_dumper_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// result_uart_dumper_if: start/status, result RAM read port and UART line.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface result_uart_dumper_if #(
   parameter int WIDTH_BITS  = 7,
   parameter int HEIGHT_BITS = 7
);
   logic                   iStart;
   logic [WIDTH_BITS-1:0]  oResultCol;
   logic [HEIGHT_BITS-1:0] oResultRow;
   logic [7:0]             iResultData;
   logic                   oTx;
   logic                   oBusy;
   logic                   oDone;

   // master is the dumper; slave is the controller, RAM and host side
   modport master (
      input  iStart,
      input  iResultData,
      output oResultCol,
      output oResultRow,
      output oTx,
      output oBusy,
      output oDone
   );

   modport slave (
      output iStart,
      output iResultData,
      input  oResultCol,
      input  oResultRow,
      input  oTx,
      input  oBusy,
      input  oDone
   );
endinterface
`default_nettype wire

// File: rtl/result_uart_dumper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// result_uart_dumper: scans the binarized result RAM, packs 8 pixels per byte
// (first pixel in the MSB) and sends them out as 8N1 UART.  Revision: 1.0
// ----------------------------------------------------------------------------
module result_uart_dumper #(
   parameter int WIDTH_BITS   = 7,
   parameter int HEIGHT_BITS  = 7,
   parameter int CLKS_PER_BIT = 868
) (
   input  wire logic            clock,
   input  wire logic            reset,
   result_uart_dumper_if.master bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]      BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [WIDTH_BITS-1:0]  COL_LAST  = '1;
   localparam logic [HEIGHT_BITS-1:0] ROW_LAST  = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LATCH = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t                 state;
   state_t                 next_state;

   logic [WIDTH_BITS-1:0]  col;
   logic [HEIGHT_BITS-1:0] row;
   logic [BAUD_W-1:0]      baud_cnt;
   logic [2:0]             bit_idx;
   logic [2:0]             pix_idx;
   logic [7:0]             shift_byte;
   logic                   last_byte;
   logic                   done;

   logic                   baud_end;
   logic                   tx;
   logic                   busy;

   assign baud_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx         = 1'b1;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.iStart) begin
               next_state = READ;
            end
         end
         READ: begin
            next_state = LATCH;
         end
         LATCH: begin
            next_state = (pix_idx == 3'd7) ? START : READ;
         end
         START: begin
            tx = 1'b0;
            if (baud_end) begin
               next_state = DATA;
            end
         end
         DATA: begin
            tx = shift_byte[bit_idx];
            if (baud_end && (bit_idx == 3'd7)) begin
               next_state = STOP;
            end
         end
         STOP: begin
            if (baud_end) begin
               next_state = last_byte ? DONE : READ;
            end
         end
         DONE: begin
            busy       = 1'b0;
            next_state = IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         baud_cnt   <= '0;
         bit_idx    <= 3'd0;
         pix_idx    <= 3'd0;
         shift_byte <= 8'd0;
         last_byte  <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.iStart) begin
                  col       <= '0;
                  row       <= '0;
                  baud_cnt  <= '0;
                  bit_idx   <= 3'd0;
                  pix_idx   <= 3'd0;
                  last_byte <= 1'b0;
                  done      <= 1'b0;
               end
            end
            LATCH: begin
               // RAM data for the address driven in READ arrives now
               shift_byte[3'd7 - pix_idx] <= (bus.iResultData != 8'd0);
               pix_idx  <= pix_idx + 3'd1;
               col      <= col + 1'b1;
               baud_cnt <= '0;
               if (col == COL_LAST) begin
                  row <= row + 1'b1;
                  if (row == ROW_LAST) begin
                     last_byte <= 1'b1;
                  end
               end
            end
            START: begin
               baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            end
            DATA: begin
               baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
               if (baud_end) begin
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: begin
               baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
               // done rises together with entering DONE, as busy falls
               if (baud_end && last_byte) begin
                  done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.oResultCol = col;
   assign bus.oResultRow = row;
   assign bus.oTx        = tx;
   assign bus.oBusy      = busy;
   assign bus.oDone      = done;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_dumper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_result_uart_dumper: directed frames on a 16x8 image at 4 clocks per bit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_result_uart_dumper;

   localparam int WB    = 4;
   localparam int HB    = 3;
   localparam int W     = 16;
   localparam int H     = 8;
   localparam int CPB   = 4;
   localparam int NB    = W * H / 8;
   localparam int FLEN  = NB * (16 + 10 * CPB);
   localparam int LIMIT = 2 * FLEN;

   logic clk;
   logic rst;

   result_uart_dumper_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

   result_uart_dumper #(
      .WIDTH_BITS(WB),
      .HEIGHT_BITS(HB),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus(bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // RAM model: registered read; the cycle right after an address change
   // shows a garbage value whose zero/nonzero sense is wrong for that address
   logic [7:0]        mem [0:H-1][0:W-1];
   logic [7:0]        mem_q;
   logic [WB+HB-1:0]  addr_d;
   logic [7:0]        rd;

   always @(posedge clk) begin
      addr_d <= {bus.oResultRow, bus.oResultCol};
      mem_q  <= mem[bus.oResultRow][bus.oResultCol];
   end

   assign rd = ({bus.oResultRow, bus.oResultCol} == addr_d) ? mem_q :
               ((mem[bus.oResultRow][bus.oResultCol] != 8'd0) ? 8'h00 : 8'h5A);
   assign bus.iResultData = rd;

   // UART monitor sampling mid-bit on falling clock edges
   logic [7:0] rx_q [$];
   int         stop_err = 0;
   logic [7:0] mon_b;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.oTx === 1'b0) begin
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               mon_b[i] = bus.oTx;
               if (i < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            if (bus.oTx !== 1'b1) stop_err++;
            rx_q.push_back(mon_b);
         end
      end
   end

   logic [7:0] exp_b [0:NB-1];

   task automatic clear_mem(input logic [7:0] v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            mem[r][c] = v;
   endtask

   // Runs one frame from a start pulse; n counts edges after the start edge.
   task automatic run_frame(input int pulse_at, output int len, output int first_fall,
                            output logic busy0, output logic busy_end);
      int n;
      rx_q.delete();
      stop_err   = 0;
      first_fall = -1;
      @(negedge clk);
      bus.iStart = 1'b1;
      @(posedge clk);
      #1;
      bus.iStart = 1'b0;
      busy0 = bus.oBusy;
      n = 0;
      while (bus.oDone !== 1'b1 && n < LIMIT) begin
         bus.iStart = (n == pulse_at);
         @(posedge clk);
         #1;
         n++;
         if (first_fall < 0 && bus.oTx === 1'b0) first_fall = n;
      end
      bus.iStart = 1'b0;
      busy_end = bus.oBusy;
      len = n;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.iStart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", bus.oTx); end
      total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.oBusy); end
      total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.oDone); end
      total++; if (bus.oResultCol !== 4'd0) begin bad++; $display("FAIL reset_col got=%0d want=0", bus.oResultCol); end
      total++; if (bus.oResultRow !== 3'd0) begin bad++; $display("FAIL reset_row got=%0d want=0", bus.oResultRow); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      int len, ff;
      logic b0, be;
      clear_mem(8'd255);
      run_frame(-1, len, ff, b0, be);
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL ones_busy_start got=%b want=1", b0); end
      total++; if (ff !== 16) begin bad++; $display("FAIL ones_first_start_bit got=%0d want=16", ff); end
      total++; if (len !== FLEN) begin bad++; $display("FAIL ones_frame_len got=%0d want=%0d", len, FLEN); end
      total++; if (be !== 1'b0) begin bad++; $display("FAIL ones_busy_at_done got=%b want=0", be); end
      total++; if (stop_err !== 0) begin bad++; $display("FAIL ones_stop_bits got=%0d want=0", stop_err); end
      total++; if (rx_q.size() !== NB) begin bad++; $display("FAIL ones_count got=%0d want=%0d", rx_q.size(), NB); end
      for (int i = 0; i < NB && i < rx_q.size(); i++) begin
         total++; if (rx_q[i] !== 8'hFF) begin bad++; $display("FAIL ones_byte%0d got=%h want=ff", i, rx_q[i]); end
      end
      repeat (5) @(posedge clk);
      #1;
      total++; if (bus.oDone !== 1'b1) begin bad++; $display("FAIL done_held got=%b want=1", bus.oDone); end
      total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.oBusy); end
      total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b want=1", bus.oTx); end
   endtask

   task automatic check_bytes_frame(input string name);
      int len, ff;
      logic b0, be;
      run_frame(-1, len, ff, b0, be);
      total++; if (len !== FLEN) begin bad++; $display("FAIL %s_frame_len got=%0d want=%0d", name, len, FLEN); end
      total++; if (rx_q.size() !== NB) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, rx_q.size(), NB); end
      for (int i = 0; i < NB && i < rx_q.size(); i++) begin
         total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL %s_byte%0d got=%h want=%h", name, i, rx_q[i], exp_b[i]); end
      end
   endtask

   task automatic test_single_pixel();
      clear_mem(8'd0);
      mem[0][0] = 8'd255;
      for (int i = 0; i < NB; i++) exp_b[i] = 8'h00;
      exp_b[0] = 8'h80;
      check_bytes_frame("pix00");
      clear_mem(8'd0);
      mem[0][1] = 8'd1;
      exp_b[0] = 8'h40;
      check_bytes_frame("pix10");
   endtask

   task automatic test_checkerboard();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            mem[r][c] = ((c + r) & 1) ? 8'd255 : 8'd0;
      for (int i = 0; i < NB; i++) exp_b[i] = ((i / 2) & 1) ? 8'hAA : 8'h55;
      check_bytes_frame("checker");
   endtask

   task automatic test_sparse();
      clear_mem(8'd0);
      mem[2][8]  = 8'd3;
      mem[7][15] = 8'd7;
      for (int i = 0; i < NB; i++) exp_b[i] = 8'h00;
      exp_b[5]  = 8'h80;
      exp_b[15] = 8'h01;
      check_bytes_frame("sparse");
   endtask

   task automatic test_reset_mid();
      clear_mem(8'd255);
      @(negedge clk);
      bus.iStart = 1'b1;
      @(posedge clk);
      #1;
      bus.iStart = 1'b0;
      repeat (480) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL midrst_tx got=%b want=1", bus.oTx); end
      total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.oBusy); end
      total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.oDone); end
      total++; if (bus.oResultCol !== 4'd0) begin bad++; $display("FAIL midrst_col got=%0d want=0", bus.oResultCol); end
      total++; if (bus.oResultRow !== 3'd0) begin bad++; $display("FAIL midrst_row got=%0d want=0", bus.oResultRow); end
      @(negedge clk);
      rst = 1'b0;
      repeat (20 * CPB) @(posedge clk);
      for (int i = 0; i < NB; i++) exp_b[i] = 8'hFF;
      check_bytes_frame("after_rst");
   endtask

   task automatic test_start_while_busy();
      int len, ff;
      logic b0, be;
      clear_mem(8'd255);
      run_frame(300, len, ff, b0, be);
      total++; if (len !== FLEN) begin bad++; $display("FAIL busy_start_len got=%0d want=%0d", len, FLEN); end
      total++; if (rx_q.size() !== NB) begin bad++; $display("FAIL busy_start_count got=%0d want=%0d", rx_q.size(), NB); end
      for (int i = 0; i < NB && i < rx_q.size(); i++) begin
         total++; if (rx_q[i] !== 8'hFF) begin bad++; $display("FAIL busy_start_byte%0d got=%h want=ff", i, rx_q[i]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.iStart = 1'b0;
      clear_mem(8'd0);
      test_reset();
      test_all_ones();
      test_single_pixel();
      test_checkerboard();
      test_sparse();
      test_reset_mid();
      test_start_while_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
